// File: rtl/mem_bank_ram.sv
// Byte-banked synchronous RAM with a 1-cycle registered read, a byte-stream boot loader and a whole-array clear engine.
// Define MEM_BANK_RAM_WR_FWD_EN for write-first forwarding; the default is read-first.
module mem_bank_ram #(
    parameter int M_WIDTH    = 32,
    parameter int ADDR_WIDTH = M_WIDTH - $clog2(M_WIDTH / 8),
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [M_WIDTH/8-1:0]    mem_we,
    input  logic [M_WIDTH-1:0]      mem_wdata,
    output logic [M_WIDTH-1:0]      mem_rdata,
    input  logic                    ld_start,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_byte,
    input  logic                    ld_last,
    output logic                    ld_ready,
    output logic                    ld_done,
    input  logic                    clr_req,
    output logic                    busy
);

    localparam int BYTES  = M_WIDTH / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int BCNT_W = DEPTH_LOG2 + LANE_W;
    localparam logic [BCNT_W-1:0]     BCNT_MAX = '1;
    localparam logic [DEPTH_LOG2-1:0] WCNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BCNT_W-1:0]       r_bcnt;
    logic [DEPTH_LOG2-1:0]   r_wcnt;
    logic [M_WIDTH-1:0]      r_mem [DEPTH];
    logic [M_WIDTH-1:0]      r_rdata;

    logic [DEPTH_LOG2-1:0]   w_raddr;
    logic [BYTES-1:0]        w_we;
    logic [DEPTH_LOG2-1:0]   w_waddr;
    logic [M_WIDTH-1:0]      w_wdata;
    logic [M_WIDTH-1:0]      w_rd_word;
    logic                    w_unused_addr;

    // Upper address bits alias onto the implemented depth.
    assign w_raddr       = mem_addr[DEPTH_LOG2-1:0];
    assign w_unused_addr = ^mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (clr_req)       w_state_nxt = S_CLEAR;
                else if (ld_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (ld_valid && (ld_last || r_bcnt == BCNT_MAX)) w_state_nxt = S_DONE;
            end
            S_CLEAR: begin
                if (r_wcnt == WCNT_MAX) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == S_DONE) begin
            r_bcnt <= '0;
            r_wcnt <= '0;
        end else begin
            if (r_state == S_LOAD && ld_valid) r_bcnt <= r_bcnt + 1'b1;
            if (r_state == S_CLEAR)            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // Single write port shared by the host side, the loader and the clear engine.
    always_comb begin
        w_we    = '0;
        w_waddr = w_raddr;
        w_wdata = mem_wdata;
        if (!rst) begin
            case (r_state)
                S_IDLE: w_we = mem_we;
                S_LOAD: begin
                    w_waddr = r_bcnt[BCNT_W-1:LANE_W];
                    w_wdata = {BYTES{ld_byte}};
                    if (ld_valid) w_we = {{(BYTES-1){1'b0}}, 1'b1} << r_bcnt[LANE_W-1:0];
                end
                S_CLEAR: begin
                    w_waddr = r_wcnt;
                    w_wdata = '0;
                    w_we    = '1;
                end
                default: w_we = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (w_we[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
        end
    end

    always_comb begin
        w_rd_word = r_mem[w_raddr];
`ifdef MEM_BANK_RAM_WR_FWD_EN
        for (int i = 0; i < BYTES; i++) begin
            if (mem_we[i]) w_rd_word[8*i +: 8] = mem_wdata[8*i +: 8];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != S_IDLE) r_rdata <= '0;
        else                          r_rdata <= w_rd_word;
    end

    assign mem_rdata = r_rdata;
    assign ld_ready  = (r_state == S_LOAD);
    assign ld_done   = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bank_ram.sv
// Bench for mem_bank_ram (M_WIDTH=32, DEPTH_LOG2=4): behavioural model with per-cycle compare plus directed literal checks.
module tb_mem_bank_ram;

    localparam int MW    = 32;
    localparam int AW    = MW - 2;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int NBYTE = DEPTH * 4;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_CLEAR = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_addr = '0;
    logic [3:0]    mem_we = '0;
    logic [MW-1:0] mem_wdata = '0;
    logic [MW-1:0] mem_rdata;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          ld_done;
    logic          clr_req = 1'b0;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic chk_en = 1'b0;

    mem_bank_ram #(.M_WIDTH(MW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done), .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: memory as a plain word array, activity as a mode plus counts.
    logic [31:0] m_mem [DEPTH];
    logic        m_known [DEPTH];
    int          m_mode = M_IDLE;
    int          m_ptr = 0;
    int          m_left = 0;
    logic [31:0] m_exp_rd = '0;
    logic        m_rd_known = 1'b1;
    logic [3:0]  m_a;
    logic [31:0] m_w;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE; m_ptr = 0; m_exp_rd = '0; m_rd_known = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_a = mem_addr[3:0];
                    m_w = m_mem[m_a];
                    m_rd_known = m_known[m_a];
`ifdef MEM_BANK_RAM_WR_FWD_EN
                    for (int i = 0; i < 4; i++)
                        if (mem_we[i]) m_w[8*i +: 8] = mem_wdata[8*i +: 8];
`endif
                    m_exp_rd = m_w;
                    for (int i = 0; i < 4; i++)
                        if (mem_we[i]) m_mem[m_a][8*i +: 8] = mem_wdata[8*i +: 8];
                    if (mem_we == 4'hF) m_known[m_a] = 1'b1;
                    if (clr_req) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            m_mem[i] = '0; m_known[i] = 1'b1;
                        end
                        m_mode = M_CLEAR; m_left = DEPTH;
                    end else if (ld_start) begin
                        m_mode = M_LOAD; m_ptr = 0;
                    end
                end
                M_LOAD: begin
                    m_exp_rd = '0; m_rd_known = 1'b1;
                    if (ld_valid) begin
                        m_mem[m_ptr / 4][8*(m_ptr % 4) +: 8] = ld_byte;
                        if (ld_last || m_ptr == NBYTE - 1) m_mode = M_DONE;
                        else m_ptr++;
                    end
                end
                M_CLEAR: begin
                    m_exp_rd = '0; m_rd_known = 1'b1;
                    m_left--;
                    if (m_left == 0) m_mode = M_DONE;
                end
                default: begin
                    m_exp_rd = '0; m_rd_known = 1'b1;
                    m_mode = M_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_rd_known) cmp("model_rdata", mem_rdata, m_exp_rd);
            cmp("model_busy", {31'd0, busy}, {31'd0, m_mode != M_IDLE});
            cmp("model_ld_ready", {31'd0, ld_ready}, {31'd0, m_mode == M_LOAD});
            cmp("model_ld_done", {31'd0, ld_done}, {31'd0, m_mode == M_DONE});
            if (ld_done) done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
        mem_addr = a; mem_we = we; mem_wdata = d;
        step();
        mem_we = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
        mem_addr = a; mem_we = '0;
        step();
        d = mem_rdata;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    logic [31:0] d;
    int n;
    int dc0;

    initial begin
        @(posedge clk);
        #1 chk_en = 1'b1;
        step(); step();
        cmp("reset_rdata", mem_rdata, 32'h0);
        cmp("reset_busy", {31'd0, busy}, 32'h0);
        cmp("reset_ld_done", {31'd0, ld_done}, 32'h0);
        rst = 1'b0;
        step();

        // Clear takes priority over load; a host write mid-clear must be dropped.
        dc0 = done_cnt;
        clr_req = 1'b1; ld_start = 1'b1;
        step();
        clr_req = 1'b0; ld_start = 1'b0;
        cmp("clear_ld_ready", {31'd0, ld_ready}, 32'h0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 5) begin mem_addr = 2; mem_we = 4'hF; mem_wdata = 32'hFFFF_FFFF; end
            else mem_we = '0;
            step();
        end
        mem_we = '0;
        cmp("clear_busy_cycles", n, 17);
        cmp("clear_done_pulses", done_cnt - dc0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i[AW-1:0], d);
            cmp($sformatf("clear_word%0d", i), d, 32'h0);
        end

        wr(3, 4'hF, 32'hDEAD_BEEF);
        rd(3, d);
        cmp("write_read_addr3", d, 32'hDEAD_BEEF);

        wr(5, 4'hF, 32'hAAAA_AAAA);
        wr(5, 4'b0101, 32'h1122_3344);
        rd(5, d);
        cmp("lane_mix_addr5", d, 32'hAA22_AA44);

        wr(25, 4'hF, 32'h0BAD_F00D);
        rd(9, d);
        cmp("alias_addr9", d, 32'h0BAD_F00D);

        mem_addr = 7; mem_we = 4'hF; mem_wdata = 32'h1234_5678;
        step();
        mem_we = '0;
`ifdef MEM_BANK_RAM_WR_FWD_EN
        cmp("rdw_addr7", mem_rdata, 32'h1234_5678);
`else
        cmp("rdw_addr7", mem_rdata, 32'h0);
`endif
        rd(7, d);
        cmp("after_rdw_addr7", d, 32'h1234_5678);

        wr(1, 4'hF, 32'h9988_7766);
        dc0 = done_cnt;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        cmp("load_ready", {31'd0, ld_ready}, 32'h1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b1);
        cmp("load_done_state", {31'd0, ld_done}, 32'h1);
        cmp("load_busy_in_done", {31'd0, busy}, 32'h1);
        step();
        cmp("load_busy_after_done", {31'd0, busy}, 32'h0);
        cmp("load_done_pulses", done_cnt - dc0, 1);
        rd(0, d);
        cmp("load_word0", d, 32'h0403_0201);
        rd(1, d);
        cmp("load_word1", d, 32'h9988_7705);

        dc0 = done_cnt;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("abort_busy", {31'd0, busy}, 32'h0);
        step(); step();
        cmp("abort_no_done", done_cnt - dc0, 0);
        rd(0, d);
        cmp("abort_word0", d, 32'h0403_B2A1);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
